// File: rtl/wb_led_pkg.sv
// ---------------------------------------------------------------------------
// wb_led_pkg
// Shared definitions for the Wishbone LED PWM controller: register word
// offsets, CTRL bit positions, address decode limits and byte-lane helpers.
// ---------------------------------------------------------------------------
package wb_led_pkg;

    // Register selection comes from byte address bits [ADDR_MSB:ADDR_LSB]
    localparam int ADDR_LSB = 2;
    localparam int ADDR_MSB = 7;

    // Word indices (byte offset / 4)
    localparam logic [5:0] REG_CTRL      = 6'h00;  // 0x00
    localparam logic [5:0] REG_ON        = 6'h01;  // 0x04
    localparam logic [5:0] REG_BLINK     = 6'h02;  // 0x08
    localparam logic [5:0] REG_PERIOD    = 6'h03;  // 0x0C
    localparam logic [5:0] REG_DUTY_BASE = 6'h10;  // 0x40 + 4*i

    // CTRL register bits
    localparam int CTRL_EN_BIT = 0;

    // Expand the four Wishbone byte enables into a 32-bit lane mask
    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    // Merge new write data into an old register value, lane by lane
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/led_pwm_chan.sv
// ---------------------------------------------------------------------------
// led_pwm_chan
// One LED channel: compares the shared PWM counter against this channel's
// duty, gates the result with global enable, the channel on bit and the
// blink phase, and registers the pad level.
//
// Ports
//   i_clk      system clock
//   i_reset_n  asynchronous active-low reset
//   i_enable   global enable (CTRL.en)
//   i_on       channel on bit
//   i_blink    channel blink mask bit
//   i_phase    shared blink phase (1 = visible half)
//   i_cnt      shared free-running PWM counter
//   i_duty     channel duty value
//   o_led      registered pad level, inverted when ACTIVE_LOW
// ---------------------------------------------------------------------------
module led_pwm_chan
    import wb_led_pkg::*;
#(
    parameter int PWM_BITS   = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_enable,
    input  logic                i_on,
    input  logic                i_blink,
    input  logic                i_phase,
    input  logic [PWM_BITS-1:0] i_cnt,
    input  logic [PWM_BITS-1:0] i_duty,
    output logic                o_led
);

    logic pwm_hit;
    logic lit;

    // Full-scale duty has to stay lit on the one count where cnt < duty fails
    always_comb begin
        pwm_hit = (i_cnt < i_duty) | (&i_duty);
        lit     = i_enable & i_on & pwm_hit & (~i_blink | i_phase);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_led <= ACTIVE_LOW;
        end else begin
            o_led <= lit ^ ACTIVE_LOW;
        end
    end

endmodule

// File: rtl/wb_led_pwm.sv
// ---------------------------------------------------------------------------
// wb_led_pwm
// Wishbone slave LED controller. Holds the register file, the shared PWM and
// blink counters, and one led_pwm_chan per LED.
//
// Register map (byte offsets)
//   0x00 CTRL   [0] global enable
//   0x04 ON     [NUM_LEDS-1:0] per-channel on bits
//   0x08 BLINK  [NUM_LEDS-1:0] per-channel blink mask
//   0x0C PERIOD [BLINK_BITS-1:0] blink half-period in clocks (0 = no blink)
//   0x40+4*i DUTY[i] [PWM_BITS-1:0]
//
// Ports
//   i_clk, i_reset_n   clock, asynchronous active-low reset
//   o_leds             LED pads (polarity per ACTIVE_LOW)
//   i_wb_addr/data/sel/we/cyc/stb   Wishbone request
//   o_wb_ack/data/err  registered response, o_wb_stall tied low
// ---------------------------------------------------------------------------
module wb_led_pwm
    import wb_led_pkg::*;
#(
    parameter int NUM_LEDS   = 6,
    parameter int PWM_BITS   = 8,
    parameter int BLINK_BITS = 24,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    output logic [NUM_LEDS-1:0] o_leds,
    input  logic [31:0]         i_wb_addr,
    input  logic [31:0]         i_wb_data,
    input  logic [3:0]          i_wb_sel,
    input  logic                i_wb_we,
    input  logic                i_wb_cyc,
    input  logic                i_wb_stb,
    output logic                o_wb_ack,
    output logic [31:0]         o_wb_data,
    output logic                o_wb_stall,
    output logic                o_wb_err
);

    localparam logic [6:0] DUTY_END = 7'(REG_DUTY_BASE) + 7'(NUM_LEDS);

    logic                  bus_valid;
    logic                  addr_mapped;
    logic                  wr_en;
    logic                  period_wr;
    logic [5:0]            reg_idx;
    logic [31:0]           wr_mask;
    logic [31:0]           rd_val;
    logic                  unused_addr_bits;

    logic                  ctrl_en;
    logic [NUM_LEDS-1:0]   on_reg;
    logic [NUM_LEDS-1:0]   blink_reg;
    logic [BLINK_BITS-1:0] period_reg;
    logic [PWM_BITS-1:0]   duty_reg [NUM_LEDS];

    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic                  blink_phase;

    logic                  ack_q;
    logic                  err_q;
    logic [31:0]           rdata_q;

    // Only [7:2] select a register; the rest of the address is don't-care
    assign unused_addr_bits = ^{i_wb_addr[31:ADDR_MSB+1], i_wb_addr[ADDR_LSB-1:0]};

    assign reg_idx     = i_wb_addr[ADDR_MSB:ADDR_LSB];
    assign bus_valid   = i_wb_cyc & i_wb_stb;
    assign wr_mask     = byte_mask(i_wb_sel);
    assign addr_mapped = (reg_idx <= REG_PERIOD) ||
                         (({1'b0, reg_idx} >= 7'(REG_DUTY_BASE)) && ({1'b0, reg_idx} < DUTY_END));
    assign wr_en       = bus_valid & i_wb_we & addr_mapped;
    assign period_wr   = wr_en & (reg_idx == REG_PERIOD);

    // Register file; writes land on the strobe edge so a read on the next
    // strobe already sees the new value
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ctrl_en    <= 1'b0;
            on_reg     <= '0;
            blink_reg  <= '0;
            period_reg <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                duty_reg[i] <= '0;
            end
        end else if (wr_en) begin
            case (reg_idx)
                REG_CTRL: begin
                    if (wr_mask[CTRL_EN_BIT]) begin
                        ctrl_en <= i_wb_data[CTRL_EN_BIT];
                    end
                end
                REG_ON:     on_reg     <= NUM_LEDS'(merge_bytes(32'(on_reg), i_wb_data, wr_mask));
                REG_BLINK:  blink_reg  <= NUM_LEDS'(merge_bytes(32'(blink_reg), i_wb_data, wr_mask));
                REG_PERIOD: period_reg <= BLINK_BITS'(merge_bytes(32'(period_reg), i_wb_data, wr_mask));
                default: begin
                    for (int i = 0; i < NUM_LEDS; i++) begin
                        if (reg_idx == REG_DUTY_BASE + 6'(i)) begin
                            duty_reg[i] <= PWM_BITS'(merge_bytes(32'(duty_reg[i]), i_wb_data, wr_mask));
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        rd_val = '0;
        case (reg_idx)
            REG_CTRL:   rd_val[CTRL_EN_BIT]    = ctrl_en;
            REG_ON:     rd_val[NUM_LEDS-1:0]   = on_reg;
            REG_BLINK:  rd_val[NUM_LEDS-1:0]   = blink_reg;
            REG_PERIOD: rd_val[BLINK_BITS-1:0] = period_reg;
            default: begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    if (reg_idx == REG_DUTY_BASE + 6'(i)) begin
                        rd_val[PWM_BITS-1:0] = duty_reg[i];
                    end
                end
            end
        endcase
    end

    // Every strobe is acknowledged; unmapped offsets also raise err and
    // return zero data
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q   <= bus_valid;
            err_q   <= bus_valid & ~addr_mapped;
            rdata_q <= (bus_valid & ~i_wb_we & addr_mapped) ? rd_val : '0;
        end
    end

    // A master that abandons the cycle must not see a stale ack
    assign o_wb_ack   = ack_q & i_wb_cyc;
    assign o_wb_err   = err_q & i_wb_cyc;
    assign o_wb_data  = rdata_q;
    assign o_wb_stall = 1'b0;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // Blink phase flips every PERIOD clocks; a PERIOD write restarts the
    // sequence in the visible half so new settings take effect at once
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (period_wr || (period_reg == '0)) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_cnt == period_reg - BLINK_BITS'(1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BLINK_BITS'(1);
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
        led_pwm_chan #(
            .PWM_BITS   (PWM_BITS),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_chan (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .i_enable  (ctrl_en),
            .i_on      (on_reg[g]),
            .i_blink   (blink_reg[g]),
            .i_phase   (blink_phase),
            .i_cnt     (pwm_cnt),
            .i_duty    (duty_reg[g]),
            .o_led     (o_leds[g])
        );
    end

endmodule

// File: tb/tb_wb_led_pwm.sv
// ---------------------------------------------------------------------------
// tb_wb_led_pwm
// Self-checking bench for wb_led_pwm. A cycle-count based model predicts the
// LED pads every clock; directed bus transfers check the register interface.
// ---------------------------------------------------------------------------
module tb_wb_led_pwm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  o_leds;
    logic [31:0] wb_addr = '0;
    logic [31:0] wb_wdata = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_ack;
    logic [31:0] wb_rdata;
    logic        wb_stall;
    logic        wb_err;

    int total = 0;
    int bad = 0;
    bit checking = 1'b0;

    // Model state: register contents plus edge counts since reset release
    logic        m_en = 1'b0;
    logic [5:0]  m_on = '0;
    logic [5:0]  m_blink = '0;
    logic [23:0] m_period = '0;
    logic [7:0]  m_duty [6] = '{default: 8'h00};
    int          m_edge = 0;
    int          m_ref = 0;
    logic [5:0]  exp_leds = 6'h3F;

    wb_led_pwm #(
        .NUM_LEDS   (6),
        .PWM_BITS   (8),
        .BLINK_BITS (24),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .o_leds     (o_leds),
        .i_wb_addr  (wb_addr),
        .i_wb_data  (wb_wdata),
        .i_wb_sel   (wb_sel),
        .i_wb_we    (wb_we),
        .i_wb_cyc   (wb_cyc),
        .i_wb_stb   (wb_stb),
        .o_wb_ack   (wb_ack),
        .o_wb_data  (wb_rdata),
        .o_wb_stall (wb_stall),
        .o_wb_err   (wb_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
        end
    endtask

    // PWM count is simply edges-since-reset mod 256; blink phase is derived
    // from how long ago PERIOD was last written
    function automatic logic [5:0] modelLeds();
        int cnt;
        int elapsed;
        bit phase;
        bit lit;
        logic [5:0] r;
        cnt = (m_edge - 1) % 256;
        if (m_period == 24'd0) begin
            phase = (m_edge >= 2);
        end else begin
            elapsed = m_edge - 1 - m_ref;
            phase = ((elapsed / int'(m_period)) % 2) == 0;
        end
        for (int i = 0; i < 6; i++) begin
            lit = m_en && m_on[i] && ((cnt < int'(m_duty[i])) || (m_duty[i] == 8'hFF))
                  && (!m_blink[i] || phase);
            r[i] = ~lit;
        end
        return r;
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] addr);
        int idx;
        idx = int'(addr[7:2]);
        case (idx)
            0: return {31'd0, m_en};
            1: return {26'd0, m_on};
            2: return {26'd0, m_blink};
            3: return {8'd0, m_period};
            default: begin
                if (idx >= 16 && idx < 22) return {24'd0, m_duty[idx-16]};
                return 32'd0;
            end
        endcase
    endfunction

    function automatic void modelWrite();
        int idx;
        logic [31:0] mask;
        logic [31:0] merged;
        idx = int'(wb_addr[7:2]);
        mask = {{8{wb_sel[3]}}, {8{wb_sel[2]}}, {8{wb_sel[1]}}, {8{wb_sel[0]}}};
        merged = (modelRead(wb_addr) & ~mask) | (wb_wdata & mask);
        case (idx)
            0: m_en = merged[0];
            1: m_on = merged[5:0];
            2: m_blink = merged[5:0];
            3: begin
                m_period = merged[23:0];
                m_ref = m_edge;
            end
            default: begin
                if (idx >= 16 && idx < 22) m_duty[idx-16] = merged[7:0];
            end
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_en = 1'b0;
            m_on = '0;
            m_blink = '0;
            m_period = '0;
            for (int i = 0; i < 6; i++) m_duty[i] = 8'h00;
            m_edge = 0;
            m_ref = 0;
            exp_leds = 6'h3F;
        end else begin
            m_edge++;
            exp_leds = modelLeds();
            if (wb_cyc && wb_stb && wb_we) modelWrite();
        end
    end

    always @(negedge clk) begin
        if (checking) checkOutput("leds", 32'(o_leds), 32'(exp_leds));
    end

    // One bus transfer: strobe for one cycle, sample the response one cycle later
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] sel, input logic we,
                                 output logic [31:0] rdata, output logic ack, output logic err);
        @(negedge clk);
        wb_addr = addr;
        wb_wdata = data;
        wb_sel = sel;
        wb_we = we;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        #1;
        checkOutput("ack early", 32'(wb_ack), 32'd0);
        @(negedge clk);
        ack = wb_ack;
        err = wb_err;
        rdata = wb_rdata;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we = 1'b0;
    endtask

    task automatic wbWrite(input string name, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] sel, input logic exp_err);
        logic [31:0] rd;
        logic ack;
        logic err;
        applyStimulus(addr, data, sel, 1'b1, rd, ack, err);
        checkOutput({name, " ack"}, 32'(ack), 32'd1);
        checkOutput({name, " err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic wbRead(input string name, input logic [31:0] addr,
                          input logic [31:0] exp_data, input logic exp_err);
        logic [31:0] rd;
        logic ack;
        logic err;
        applyStimulus(addr, 32'd0, 4'hF, 1'b0, rd, ack, err);
        checkOutput({name, " ack"}, 32'(ack), 32'd1);
        checkOutput({name, " err"}, 32'(err), 32'(exp_err));
        checkOutput({name, " data"}, rd, exp_data);
    endtask

    task automatic countLow(input int bit_idx, input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (o_leds[bit_idx] == 1'b0) n++;
        end
    endtask

    // Cycles between two consecutive changes of o_leds[0]; -1 on timeout
    task automatic measureGap(output int gap);
        logic prev;
        int waited;
        gap = -1;
        @(negedge clk);
        prev = o_leds[0];
        waited = 0;
        while (o_leds[0] == prev && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (o_leds[0] == prev) return;
        prev = o_leds[0];
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (o_leds[0] == prev && gap < 50);
        if (o_leds[0] == prev) gap = -1;
    endtask

    initial begin
        logic [31:0] reg_list [10];
        int n;
        int gap;

        reg_list = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h40, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h54};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checking = 1'b1;
        @(negedge clk);
        checkOutput("reset leds", 32'(o_leds), 32'h3F);
        checkOutput("reset ack", 32'(wb_ack), 32'd0);
        checkOutput("reset err", 32'(wb_err), 32'd0);
        checkOutput("reset data", wb_rdata, 32'd0);
        checkOutput("stall", 32'(wb_stall), 32'd0);
        foreach (reg_list[i]) wbRead("reset reg", reg_list[i], 32'd0, 1'b0);

        // Steady full-scale channel and a quarter-duty channel
        wbWrite("ctrl", 32'h00, 32'h1, 4'hF, 1'b0);
        wbWrite("on", 32'h04, 32'h3F, 4'hF, 1'b0);
        wbWrite("duty0", 32'h40, 32'hFF, 4'hF, 1'b0);
        wbWrite("duty1", 32'h44, 32'h40, 4'hF, 1'b0);
        repeat (2) @(negedge clk);
        countLow(0, 256, n);
        checkOutput("duty0 lit count", 32'(n), 32'd256);
        countLow(1, 256, n);
        checkOutput("duty1 lit count", 32'(n), 32'd64);

        // Blink channel 0 with a 10-cycle half-period, then stop blinking
        wbWrite("blink", 32'h08, 32'h01, 4'hF, 1'b0);
        wbWrite("period10", 32'h0C, 32'd10, 4'hF, 1'b0);
        measureGap(gap);
        checkOutput("blink gap a", 32'(gap), 32'd10);
        measureGap(gap);
        checkOutput("blink gap b", 32'(gap), 32'd10);
        wbWrite("period0", 32'h0C, 32'd0, 4'hF, 1'b0);
        repeat (2) @(negedge clk);
        countLow(0, 40, n);
        checkOutput("period0 steady", 32'(n), 32'd40);

        // Byte enables
        wbWrite("on clear", 32'h04, 32'h0, 4'hF, 1'b0);
        wbWrite("on sel1", 32'h04, 32'hFFFF_FFFF, 4'b0010, 1'b0);
        wbRead("on after sel1", 32'h04, 32'h00, 1'b0);
        wbWrite("on sel0", 32'h04, 32'hFFFF_FFFF, 4'b0001, 1'b0);
        wbRead("on after sel0", 32'h04, 32'h3F, 1'b0);
        @(negedge clk);
        checkOutput("ack gone", 32'(wb_ack), 32'd0);
        wbWrite("duty2 sel1", 32'h48, 32'h1234_5678, 4'b0010, 1'b0);
        wbRead("duty2 after sel1", 32'h48, 32'h00, 1'b0);
        wbWrite("duty2 sel0", 32'h48, 32'h1234_5678, 4'b0001, 1'b0);
        wbRead("duty2 after sel0", 32'h48, 32'h78, 1'b0);
        wbWrite("duty5", 32'h54, 32'hA5, 4'hF, 1'b0);
        wbRead("duty5", 32'h54, 32'hA5, 1'b0);

        // Unmapped offsets: ack with err, zero data, no side effects
        wbRead("read 0x80", 32'h80, 32'd0, 1'b1);
        wbWrite("write 0x80", 32'h80, 32'hFFFF_FFFF, 4'hF, 1'b1);
        wbWrite("write 0x10", 32'h10, 32'hFFFF_FFFF, 4'hF, 1'b1);
        wbWrite("write 0x58", 32'h58, 32'hFFFF_FFFF, 4'hF, 1'b1);
        foreach (reg_list[i]) wbRead("after err", reg_list[i], modelRead(reg_list[i]), 1'b0);

        // Back-to-back strobes: write then immediately read the same register
        @(negedge clk);
        wb_addr = 32'h4C; wb_wdata = 32'h5A; wb_sel = 4'hF; wb_we = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        @(negedge clk);
        checkOutput("b2b ack1", 32'(wb_ack), 32'd1);
        wb_we = 1'b0;
        @(negedge clk);
        checkOutput("b2b ack2", 32'(wb_ack), 32'd1);
        checkOutput("b2b data", wb_rdata, 32'h5A);
        wb_cyc = 1'b0; wb_stb = 1'b0;

        // Master drops cyc in the ack cycle
        @(negedge clk);
        wb_addr = 32'h00; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        #1;
        checkOutput("ack suppressed", 32'(wb_ack), 32'd0);

        // Reset lands while a write is strobed
        @(negedge clk);
        wb_addr = 32'h08; wb_wdata = 32'h15; wb_sel = 4'hF; wb_we = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset ack", 32'(wb_ack), 32'd0);
        checkOutput("reset leds mid", 32'(o_leds), 32'h3F);
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wbRead("blink after reset", 32'h08, 32'h00, 1'b0);
        wbRead("on after reset", 32'h04, 32'h00, 1'b0);

        repeat (3) @(negedge clk);
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop if something above never returns
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running, wanted finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
